// File: rtl/best_idx_readout.sv
// Reads K k-best index banks one address at a time and streams the words over a valid/ready port.
// Define KBEST_COMPUTE1_EN to also stream the compute-1 field (2K beats per address instead of K).
module best_idx_readout #(
  parameter  int K          = 4,
  parameter  int IDX_WIDTH  = 9,
  parameter  int NUM_LEAVES = 64,
  localparam int LEAF_ADDRW = $clog2(NUM_LEAVES),
  localparam int W          = LEAF_ADDRW + IDX_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8:0]          last_addr,
  output logic [K-1:0]        csb1,
  output logic [8:0]          addr1,
  input  logic [K-1:0][W-1:0] compute0_ridx_1,
  input  logic [K-1:0][W-1:0] compute1_ridx_1,
  output logic [W-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

`ifdef KBEST_COMPUTE1_EN
  localparam int NB = 2 * K;
`else
  localparam int NB = K;
`endif
  localparam int                BEAT_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_STREAM  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [8:0]        r_addr;
  logic [8:0]        r_last_addr;
  logic [BEAT_W-1:0] r_beat;
  logic [W-1:0]      r_buf [NB];
  logic              w_hs;
  logic              w_final_addr;
  logic              w_last_beat;
  logic              w_start_ok;

  assign w_hs         = (r_state == S_STREAM) && out_ready;
  assign w_final_addr = (r_addr == r_last_addr);
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_start_ok   = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_READ;
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_STREAM;
      S_STREAM:  if (w_hs && w_last_beat) w_next = w_final_addr ? S_DONE : S_READ;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    csb1      = '1;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE:   busy = 1'b0;
      S_READ:   csb1 = '0;
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = r_buf[r_beat];
        out_last  = w_final_addr && w_last_beat;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  assign addr1 = r_addr;

  // The final address is never incremented, so last_addr = 511 cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_last_addr <= '0;
      r_beat      <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr      <= '0;
        r_last_addr <= last_addr;
      end else if (w_hs && w_last_beat && !w_final_addr) begin
        r_addr <= r_addr + 9'd1;
      end
      if (w_hs) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
    end
  end

  // Bank data is valid the cycle after READ, i.e. during CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) r_buf[i] <= '0;
    end else if (r_state == S_CAPTURE) begin
      for (int k = 0; k < K; k++) begin
        r_buf[k] <= compute0_ridx_1[k];
`ifdef KBEST_COMPUTE1_EN
        r_buf[K+k] <= compute1_ridx_1[k];
`endif
      end
    end
  end

`ifndef KBEST_COMPUTE1_EN
  logic w_unused_c1;
  assign w_unused_c1 = ^compute1_ridx_1;
`endif

endmodule
